axis_byte_packer: RTL

AXIS_BYTE_PACKER -- requirements
Module: axis_byte_packer

---
 rtl/axis_pack_pkg.sv | 18 +
 rtl/axis_byte_packer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pack_pkg.sv
// Shared definitions for the AXI-Stream byte packer: FSM encodings and lane-count helpers.
package axis_pack_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FILL  = 2'd1,
    ST_FULL  = 2'd2
  } pack_state_t;

  function automatic int lane_count(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int lane_idx_w(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/axis_byte_packer.sv
// Packs an 8-bit AXI-Stream into M_DATA_WIDTH-bit words, first byte in lane 0,
// closing words on a full lane set, tlast, or a tid/tdest change.
module axis_byte_packer
  import axis_pack_pkg::*;
#(
  parameter int M_DATA_WIDTH = 64,
  parameter int ID_ENABLE    = 1,
  parameter int ID_WIDTH     = 8,
  parameter int DEST_ENABLE  = 1,
  parameter int DEST_WIDTH   = 8,
  parameter int USER_ENABLE  = 1,
  parameter int USER_WIDTH   = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [7:0]                s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic                      s_axis_tlast,
  input  logic [ID_WIDTH-1:0]       s_axis_tid,
  input  logic [DEST_WIDTH-1:0]     s_axis_tdest,
  input  logic [USER_WIDTH-1:0]     s_axis_tuser,
  output logic [M_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [M_DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast,
  output logic [ID_WIDTH-1:0]       m_axis_tid,
  output logic [DEST_WIDTH-1:0]     m_axis_tdest,
  output logic [USER_WIDTH-1:0]     m_axis_tuser,
  output logic                      status_id_break
);

  localparam int LANES = lane_count(M_DATA_WIDTH);
  localparam int IDX_W = lane_idx_w(LANES);

  logic [ID_WIDTH-1:0]   s_id;
  logic [DEST_WIDTH-1:0] s_dest;
  logic [USER_WIDTH-1:0] s_user;

  assign s_id   = (ID_ENABLE   != 0) ? s_axis_tid   : '0;
  assign s_dest = (DEST_ENABLE != 0) ? s_axis_tdest : '0;
  assign s_user = (USER_ENABLE != 0) ? s_axis_tuser : '0;

  pack_state_t state, state_nxt;
  logic                    run_q;
  logic [IDX_W-1:0]        cnt_p0, cnt_nxt;

  logic [M_DATA_WIDTH-1:0] acc_data_p0, acc_data_nxt;
  logic [LANES-1:0]        acc_keep_p0, acc_keep_nxt;
  logic                    acc_last_p0, acc_last_nxt;
  logic [ID_WIDTH-1:0]     acc_id_p0, acc_id_nxt;
  logic [DEST_WIDTH-1:0]   acc_dest_p0, acc_dest_nxt;
  logic [USER_WIDTH-1:0]   acc_user_p0, acc_user_nxt;

  logic [M_DATA_WIDTH-1:0] word_data;
  logic [LANES-1:0]        word_keep;
  logic [ID_WIDTH-1:0]     word_id;
  logic [DEST_WIDTH-1:0]   word_dest;

  logic                    load_out;
  logic [M_DATA_WIDTH-1:0] ld_data;
  logic [LANES-1:0]        ld_keep;
  logic                    ld_last;
  logic [ID_WIDTH-1:0]     ld_id;
  logic [DEST_WIDTH-1:0]   ld_dest;
  logic [USER_WIDTH-1:0]   ld_user;

  logic [M_DATA_WIDTH-1:0] out_data_p1;
  logic [LANES-1:0]        out_keep_p1;
  logic                    out_last_p1;
  logic [ID_WIDTH-1:0]     out_id_p1;
  logic [DEST_WIDTH-1:0]   out_dest_p1;
  logic [USER_WIDTH-1:0]   out_user_p1;
  logic                    vld_p1;

  logic out_free, id_diff, ready, accept, closing, brk;

  // Stage p0: accumulator and FSM
  always_comb begin
    out_free = !vld_p1 || m_axis_tready;
    id_diff  = (state == ST_FILL) && s_axis_tvalid &&
               ((s_id != acc_id_p0) || (s_dest != acc_dest_p0));
    ready    = run_q && ((state == ST_EMPTY) || ((state == ST_FILL) && !id_diff));
    accept   = s_axis_tvalid && ready;
    closing  = accept && (s_axis_tlast || (cnt_p0 == IDX_W'(LANES - 1)));

    // An empty accumulator starts from zero so unused lanes of short words read as 0.
    word_data = (state == ST_EMPTY) ? '0 : acc_data_p0;
    word_keep = (state == ST_EMPTY) ? '0 : acc_keep_p0;
    for (int k = 0; k < LANES; k++) begin
      if (IDX_W'(k) == cnt_p0) begin
        word_data[8*k +: 8] = s_axis_tdata;
        word_keep[k]        = 1'b1;
      end
    end
    word_id   = (state == ST_EMPTY) ? s_id   : acc_id_p0;
    word_dest = (state == ST_EMPTY) ? s_dest : acc_dest_p0;

    state_nxt    = state;
    cnt_nxt      = cnt_p0;
    acc_data_nxt = acc_data_p0;
    acc_keep_nxt = acc_keep_p0;
    acc_last_nxt = acc_last_p0;
    acc_id_nxt   = acc_id_p0;
    acc_dest_nxt = acc_dest_p0;
    acc_user_nxt = acc_user_p0;
    load_out     = 1'b0;
    ld_data      = acc_data_p0;
    ld_keep      = acc_keep_p0;
    ld_last      = acc_last_p0;
    ld_id        = acc_id_p0;
    ld_dest      = acc_dest_p0;
    ld_user      = acc_user_p0;
    brk          = 1'b0;

    case (state)
      ST_EMPTY, ST_FILL: begin
        if (id_diff) begin
          // Stream identity changed mid-word: flush the partial word without tlast.
          brk          = 1'b1;
          ld_last      = 1'b0;
          acc_last_nxt = 1'b0;
          cnt_nxt      = '0;
          if (out_free) begin
            load_out  = 1'b1;
            state_nxt = ST_EMPTY;
          end else begin
            state_nxt = ST_FULL;
          end
        end else if (accept) begin
          acc_data_nxt = word_data;
          acc_keep_nxt = word_keep;
          acc_last_nxt = s_axis_tlast;
          acc_id_nxt   = word_id;
          acc_dest_nxt = word_dest;
          acc_user_nxt = s_user;
          if (closing) begin
            cnt_nxt = '0;
            ld_data = word_data;
            ld_keep = word_keep;
            ld_last = s_axis_tlast;
            ld_id   = word_id;
            ld_dest = word_dest;
            ld_user = s_user;
            if (out_free) begin
              load_out  = 1'b1;
              state_nxt = ST_EMPTY;
            end else begin
              state_nxt = ST_FULL;
            end
          end else begin
            cnt_nxt   = cnt_p0 + IDX_W'(1);
            state_nxt = ST_FILL;
          end
        end
      end
      ST_FULL: begin
        if (out_free) begin
          load_out  = 1'b1;
          cnt_nxt   = '0;
          state_nxt = ST_EMPTY;
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = ST_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_EMPTY;
      cnt_p0 <= '0;
      run_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt_p0 <= cnt_nxt;
      run_q  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    acc_data_p0 <= acc_data_nxt;
    acc_keep_p0 <= acc_keep_nxt;
    acc_last_p0 <= acc_last_nxt;
    acc_id_p0   <= acc_id_nxt;
    acc_dest_p0 <= acc_dest_nxt;
    acc_user_p0 <= acc_user_nxt;
  end

  // Stage p1: output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1      <= 1'b0;
      out_data_p1 <= '0;
      out_keep_p1 <= '0;
      out_last_p1 <= 1'b0;
      out_id_p1   <= '0;
      out_dest_p1 <= '0;
      out_user_p1 <= '0;
    end else if (load_out) begin
      vld_p1      <= 1'b1;
      out_data_p1 <= ld_data;
      out_keep_p1 <= ld_keep;
      out_last_p1 <= ld_last;
      out_id_p1   <= ld_id;
      out_dest_p1 <= ld_dest;
      out_user_p1 <= ld_user;
    end else if (m_axis_tready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign s_axis_tready   = ready;
  assign status_id_break = brk;
  assign m_axis_tvalid   = vld_p1;
  assign m_axis_tdata    = out_data_p1;
  assign m_axis_tkeep    = out_keep_p1;
  assign m_axis_tlast    = out_last_p1;
  assign m_axis_tid      = out_id_p1;
  assign m_axis_tdest    = out_dest_p1;
  assign m_axis_tuser    = out_user_p1;

endmodule
